// File: rtl/expand_mask_pkg.sv
// expand_mask_pkg: ML-DSA-87 ExpandMask parameters, FSM state type and coefficient mapping
package expand_mask_pkg;
    localparam int L                    = 7;
    localparam int GAMMA1               = 19;
    localparam int COEFF_BIT_LEN        = 20;
    localparam int WORD_WIDTH           = 64;
    localparam int COEFF_WIDTH          = 24;
    localparam int COEFF_PER_WORD       = 4;
    localparam int NTT_ADDR_WIDTH       = 12;
    localparam int VECTOR_Y_BASE_OFFSET = 0;
    localparam int SEED_WORDS           = 8;
    localparam int WORDS_PER_POLY       = 80;
    localparam int WRITES_PER_POLY      = 64;
    localparam int GROUP_BITS           = COEFF_BIT_LEN * COEFF_PER_WORD;
    localparam int BUF_WIDTH            = GROUP_BITS + WORD_WIDTH;
    localparam int RAM_WIDTH            = COEFF_WIDTH * COEFF_PER_WORD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RST_SPONGE,
        S_ABSORB,
        S_SQUEEZE,
        S_DONE
    } state_t;

    // y = gamma1 - raw, two's complement in COEFF_WIDTH bits
    function automatic logic [COEFF_WIDTH-1:0] to_coeff(input logic [COEFF_BIT_LEN-1:0] raw);
        return COEFF_WIDTH'(1 << GAMMA1) - COEFF_WIDTH'(raw);
    endfunction
endpackage

// File: rtl/expand_mask_bit_unpacker.sv
// expand_mask_bit_unpacker: LSB-first bit buffer turning 64b sponge words into groups of 4 signed coeffs
// clk/rst   clock, async active-high reset
// clr       synchronous flush between polys
// push/data accept one 64b word (only when can_push)
// pop       consume one 80b group (only when can_pop)
// coeffs    4 x 24b coefficients decoded from the oldest 80 bits
module expand_mask_bit_unpacker
    import expand_mask_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WORD_WIDTH-1:0] data,
    output logic                  can_push,
    output logic                  can_pop,
    output logic [RAM_WIDTH-1:0]  coeffs
);
    logic [BUF_WIDTH-1:0] bits_q, kept;
    logic [7:0]           cnt_q, base;

    always_comb begin
        kept = pop ? bits_q >> GROUP_BITS : bits_q;
        base = pop ? cnt_q - 8'(GROUP_BITS) : cnt_q;
    end

    // a push is only allowed with <=80 bits held, so the new word always fits above the kept bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_q <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            bits_q <= '0;
            cnt_q  <= '0;
        end else begin
            bits_q <= push ? kept | (BUF_WIDTH'(data) << base) : kept;
            cnt_q  <= base + (push ? 8'(WORD_WIDTH) : 8'd0);
        end
    end

    assign can_push = cnt_q <= 8'(BUF_WIDTH - WORD_WIDTH);
    assign can_pop  = cnt_q >= 8'(GROUP_BITS);

    for (genvar j = 0; j < COEFF_PER_WORD; j++) begin : g_coeff
        assign coeffs[j*COEFF_WIDTH +: COEFF_WIDTH] = to_coeff(bits_q[j*COEFF_BIT_LEN +: COEFF_BIT_LEN]);
    end
endmodule

// File: rtl/expand_mask.sv
// expand_mask: ML-DSA ExpandMask, drives an external SHAKE256 sponge and writes vector y into RAM
// clk/rst            clock, async active-high reset
// start/mu/rho       start pulse with counter mu, then 8 seed words on consecutive cycles
// done               one-cycle pulse after the final RAM write
// *_vector_y         RAM port A write (4 coeffs per word, addr = base + r*64 + k)
// absorb_next_poly   one-cycle sponge soft reset before each poly
// shake_data_in, in_valid, in_last, last_len, in_ready   absorb handshake
// shake_data_out, out_valid, out_ready                    squeeze handshake
// cache_rd/cache_wr  sponge state cache controls, unused
module expand_mask
    import expand_mask_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WORD_WIDTH-1:0]     rho,
    input  logic [15:0]               mu,
    output logic                      done,
    output logic                      we_vector_y,
    output logic [NTT_ADDR_WIDTH-1:0] addr_vector_y,
    output logic [RAM_WIDTH-1:0]      din_vector_y,
    output logic                      absorb_next_poly,
    output logic [WORD_WIDTH-1:0]     shake_data_in,
    output logic                      in_valid,
    output logic                      in_last,
    output logic [6:0]                last_len,
    output logic                      cache_rd,
    output logic                      cache_wr,
    output logic                      out_ready,
    input  logic [WORD_WIDTH-1:0]     shake_data_out,
    input  logic                      out_valid,
    input  logic                      in_ready
);
    state_t                state;
    logic [WORD_WIDTH-1:0] seed [SEED_WORDS];
    logic [15:0]           mu_q, ctr;
    logic [2:0]            ld_cnt, r;
    logic [3:0]            abs_cnt;
    logic [6:0]            sq_cnt;
    logic [5:0]            k;
    logic                  can_push, can_pop, push, pop;
    logic [RAM_WIDTH-1:0]  coeffs;

    assign ctr              = mu_q + 16'(r);
    assign in_valid         = state == S_ABSORB;
    assign in_last          = in_valid && abs_cnt == 4'(SEED_WORDS);
    assign last_len         = in_last ? 7'd16 : 7'd0;
    assign shake_data_in    = !in_valid ? '0 : in_last ? {48'b0, ctr} : seed[abs_cnt[2:0]];
    assign absorb_next_poly = state == S_RST_SPONGE;
    assign out_ready        = state == S_SQUEEZE && sq_cnt < 7'(WORDS_PER_POLY) && can_push;
    assign push             = out_ready && out_valid;
    assign pop              = state == S_SQUEEZE && can_pop;
    assign cache_rd         = 1'b0;
    assign cache_wr         = 1'b0;

    expand_mask_bit_unpacker u_unpack (
        .clk      (clk),
        .rst      (rst),
        .clr      (absorb_next_poly),
        .push     (push),
        .pop      (pop),
        .data     (shake_data_out),
        .can_push (can_push),
        .can_pop  (can_pop),
        .coeffs   (coeffs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            for (int i = 0; i < SEED_WORDS; i++) seed[i] <= '0;
            mu_q          <= '0;
            ld_cnt        <= '0;
            r             <= '0;
            abs_cnt       <= '0;
            sq_cnt        <= '0;
            k             <= '0;
            done          <= 1'b0;
            we_vector_y   <= 1'b0;
            addr_vector_y <= '0;
            din_vector_y  <= '0;
        end else begin
            done        <= 1'b0;
            we_vector_y <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state  <= S_LOAD;
                    mu_q   <= mu;
                    ld_cnt <= '0;
                    r      <= '0;
                end
                S_LOAD: begin
                    seed[ld_cnt] <= rho;
                    ld_cnt       <= ld_cnt + 3'd1;
                    if (ld_cnt == 3'(SEED_WORDS - 1)) state <= S_RST_SPONGE;
                end
                S_RST_SPONGE: begin
                    abs_cnt <= '0;
                    sq_cnt  <= '0;
                    k       <= '0;
                    state   <= S_ABSORB;
                end
                S_ABSORB: if (in_ready) begin
                    abs_cnt <= abs_cnt + 4'd1;
                    if (in_last) state <= S_SQUEEZE;
                end
                S_SQUEEZE: begin
                    if (push) sq_cnt <= sq_cnt + 7'd1;
                    if (pop) begin
                        we_vector_y   <= 1'b1;
                        addr_vector_y <= NTT_ADDR_WIDTH'(VECTOR_Y_BASE_OFFSET) + NTT_ADDR_WIDTH'({r, k});
                        din_vector_y  <= coeffs;
                        k             <= k + 6'd1;
                        // 64 groups of 80 bits consume exactly the 80 squeezed words
                        if (k == 6'(WRITES_PER_POLY - 1)) begin
                            r     <= r + 3'd1;
                            state <= r == 3'(L - 1) ? S_DONE : S_RST_SPONGE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_expand_mask.sv
// tb_expand_mask: sponge model plus scoreboard checking absorb traffic and every vector-y RAM write
module tb_expand_mask;
    import expand_mask_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [63:0] rho = '0;
    logic [15:0] mu = '0;
    logic        done, we_vector_y, absorb_next_poly, in_valid, in_last, cache_rd, cache_wr, out_ready;
    logic [11:0] addr_vector_y;
    logic [95:0] din_vector_y;
    logic [63:0] shake_data_in;
    logic [6:0]  last_len;
    logic [63:0] shake_data_out = '0;
    logic        out_valid = 1'b0, in_ready = 1'b0;

    expand_mask dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .rho              (rho),
        .mu               (mu),
        .done             (done),
        .we_vector_y      (we_vector_y),
        .addr_vector_y    (addr_vector_y),
        .din_vector_y     (din_vector_y),
        .absorb_next_poly (absorb_next_poly),
        .shake_data_in    (shake_data_in),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .last_len         (last_len),
        .cache_rd         (cache_rd),
        .cache_wr         (cache_wr),
        .out_ready        (out_ready),
        .shake_data_out   (shake_data_out),
        .out_valid        (out_valid),
        .in_ready         (in_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [95:0] d;
    } wr_t;

    wr_t         sb[$];
    logic [63:0] sq_q[$];
    logic [63:0] cur_seed[8];
    logic [15:0] cur_mu = '0;
    int          total = 0, bad = 0;
    int          wr_cnt = 0, anp_cnt = 0, abs_words = 0, poly_i = 0, abs_k = 0, mode = 0;
    bit          stall = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: sponge output for this poly is a 5120-bit stream; coeff i is gamma1 minus bits [20i+19:20i]
    task automatic new_poly();
        logic [5119:0] bs;
        logic [63:0]   w;
        wr_t           e;
        int            raw, y;
        for (int i = 0; i < 80; i++) begin
            if (mode == 0) w = {$urandom, $urandom};
            else if (mode == 1) w = '0;
            else w = '1;
            bs[64*i +: 64] = w;
            sq_q.push_back(w);
        end
        for (int kk = 0; kk < 64; kk++) begin
            e.a = 12'(poly_i * 64 + kk);
            e.d = '0;
            for (int j = 0; j < 4; j++) begin
                raw = int'(bs[20*(4*kk+j) +: 20]);
                y = 524288 - raw;
                e.d[24*j +: 24] = y[23:0];
            end
            sb.push_back(e);
        end
        abs_k = 0;
        anp_cnt++;
        poly_i++;
    endtask

    // sponge model: drives handshakes at negedge, observes transfers just before the next posedge
    initial forever begin
        logic [63:0] exp_w;
        logic        exp_last;
        @(negedge clk);
        if (absorb_next_poly) new_poly();
        in_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        out_valid = sq_q.size() > 0 && (!stall || $urandom_range(0, 2) != 0);
        shake_data_out = sq_q.size() > 0 ? sq_q[0] : '0;
        #1;
        if (in_valid && in_ready) begin
            exp_last = abs_k == 8;
            exp_w = abs_k < 8 ? cur_seed[abs_k] : {48'b0, 16'(cur_mu + 16'(poly_i - 1))};
            chk("absorb_word", {shake_data_in, in_last, last_len}, {exp_w, exp_last, exp_last ? 7'd16 : 7'd0});
            abs_k++;
            abs_words++;
        end
        if (out_valid && out_ready) void'(sq_q.pop_front());
    end

    // monitor: every RAM write must match the oldest scoreboard entry
    initial forever begin
        wr_t e;
        @(negedge clk);
        if (we_vector_y) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ram_write: unexpected write addr=%0h din=%0h", addr_vector_y, din_vector_y);
            end else begin
                e = sb.pop_front();
                chk("ram_write", {addr_vector_y, din_vector_y}, {e.a, e.d});
            end
        end
    end

    task automatic launch(input int m, input bit st, input logic [15:0] mu_v, input bit fixed);
        mode = m;
        stall = st;
        poly_i = 0;
        wr_cnt = 0;
        anp_cnt = 0;
        abs_words = 0;
        for (int i = 0; i < 8; i++) cur_seed[i] = fixed ? 64'h1234567890abcdef : {$urandom, $urandom};
        cur_mu = mu_v;
        @(negedge clk);
        start = 1'b1;
        mu = mu_v;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            rho = cur_seed[i];
            mu = 16'($urandom);
        end
        @(negedge clk);
        rho = {$urandom, $urandom};
    endtask

    task automatic run(input int m, input bit st, input logic [15:0] mu_v, input bit fixed, input bit busy_start);
        int n;
        launch(m, st, mu_v, fixed);
        if (busy_start) begin
            repeat (40) @(negedge clk);
            start = 1'b1;
            mu = 16'h5555;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        chk("writes_at_done", wr_cnt, 448);
        chk("absorb_pulses", anp_cnt, 7);
        chk("absorb_words", abs_words, 63);
        chk("scoreboard_drained", sb.size(), 0);
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        repeat (2) @(negedge clk);
        chk("idle_outputs", {we_vector_y, done, in_valid, out_ready, absorb_next_poly}, 0);
    endtask

    task automatic mid_reset();
        int n;
        launch(0, 0, 16'h0042, 0);
        n = 0;
        while (wr_cnt < 70 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_poly1_squeeze", wr_cnt >= 70, 1);
        rst = 1'b1;
        #1;
        chk("rst_ctl", {we_vector_y, done, absorb_next_poly, in_valid, in_last, out_ready, last_len, cache_rd, cache_wr}, 0);
        chk("rst_data", {addr_vector_y, din_vector_y}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_write_in_rst", we_vector_y, 0);
        end
        sb.delete();
        sq_q.delete();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_write_after_rst", {we_vector_y, done, in_valid}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ctl", {we_vector_y, done, absorb_next_poly, in_valid, in_last, out_ready, last_len, cache_rd, cache_wr}, 0);
        chk("reset_data", {addr_vector_y, din_vector_y, shake_data_in}, 0);
        rst = 1'b0;
        @(negedge clk);
        run(0, 0, 16'h0001, 1, 0);
        run(0, 1, 16'($urandom), 0, 1);
        run(1, 0, 16'($urandom), 0, 0);
        run(2, 1, 16'($urandom), 0, 0);
        run(0, 1, 16'hFFFF, 0, 0);
        mid_reset();
        run(0, 0, 16'hFFFE, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
